aes_key_memory: RTL and testbench

AES_KEY_MEMORY -- requirements
Module: aes_key_memory

---
 rtl/aes_key_memory.sv | 118 +++++++++++
 tb/tb_aes_key_memory.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/aes_key_memory.sv
// AES-128 key-expansion step: one round key in, next round key out (Rcon chosen by times).
// Latency: 0 cycles (combinational); 1 cycle when AES_KEY_MEMORY_OUTREG_EN is defined.
// Backpressure: none; every input is accepted every cycle, with no handshake.
module aes_key_memory (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   times,
  input  logic [127:0] key,
  output logic [127:0] keyout
);

  // Round constant for rounds 1..10; codes 0 and 11..15 never reach the output path.
  function automatic logic [7:0] rcon(input logic [3:0] t);
    logic [7:0] r;
    r = 8'h00;
    case (t)
      4'd1:  r = 8'h01;
      4'd2:  r = 8'h02;
      4'd3:  r = 8'h04;
      4'd4:  r = 8'h08;
      4'd5:  r = 8'h10;
      4'd6:  r = 8'h20;
      4'd7:  r = 8'h40;
      4'd8:  r = 8'h80;
      4'd9:  r = 8'h1b;
      4'd10: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Forward AES S-box as a flat lookup table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = 8'h00;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, temp_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] keyout_d;

  // One expansion step; round 0 and illegal codes 11..15 pass the key straight through.
  always_comb begin
    w0     = key[127:96];
    w1     = key[95:64];
    w2     = key[63:32];
    w3     = key[31:0];
    rot_w  = {w3[23:0], w3[31:24]};
    sub_w  = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    temp_w = sub_w ^ {rcon(times), 24'h000000};
    n0     = w0 ^ temp_w;
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
    if ((times == 4'd0) || (times > 4'd10)) begin
      keyout_d = key;
    end else begin
      keyout_d = {n0, n1, n2, n3};
    end
  end

`ifdef AES_KEY_MEMORY_OUTREG_EN
  logic [127:0] keyout_q;

  // Output register: cleared asynchronously, loads the next round key every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyout_q <= 128'h0;
    end else begin
      keyout_q <= keyout_d;
    end
  end

  assign keyout = keyout_q;
`else
  // Purely combinational build: clock and reset have no loads.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign keyout         = keyout_d;
`endif

endmodule

// File: tb/tb_aes_key_memory.sv
// Bench for aes_key_memory: directed FIPS-197 vectors, full 11-round chain, random keys/rounds.
// Reference S-box and Rcon are derived from GF(2^8) arithmetic, not from a table.
// Define AES_KEY_MEMORY_OUTREG_EN for both files to check the registered build.
module tb_aes_key_memory;

  logic         clk;
  logic         rst_n;
  logic [3:0]   times;
  logic [127:0] key;
  logic [127:0] keyout;

  int n_chk;
  int n_pass;

  logic [7:0] ref_sbox [256];
  logic [7:0] ref_rcon [11];

  aes_key_memory dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .times  (times),
    .key    (key),
    .keyout (keyout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Build the S-box from multiplicative inverse plus the affine transform.
  task automatic build_tables();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    ref_rcon[0] = 8'h00;
    ref_rcon[1] = 8'h01;
    for (int i = 2; i < 11; i++) ref_rcon[i] = gmul(ref_rcon[i-1], 8'h02);
  endtask

  function automatic logic [127:0] ref_next(input logic [127:0] k, input logic [3:0] t);
    logic [31:0] w [4];
    logic [7:0]  b [4];
    logic [31:0] tmp;
    if (t == 4'd0 || t > 4'd10) return k;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    // RotWord then SubWord, byte by byte
    for (int i = 0; i < 4; i++) b[i] = ref_sbox[w[3][31 - 8*((i + 1) % 4) -: 8]];
    tmp = {b[0] ^ ref_rcon[t], b[1], b[2], b[3]};
    w[0] = w[0] ^ tmp;
    for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %032h expected %032h", tag, got, exp);
    end
  endtask

  // Drive one input set shortly after a rising edge and check at the point the result is due.
  task automatic apply(input string tag, input logic [127:0] k, input logic [3:0] t,
                       input logic [127:0] exp);
    @(posedge clk);
    #1;
    key   = k;
    times = t;
`ifdef AES_KEY_MEMORY_OUTREG_EN
    @(posedge clk);
    #1;
`else
    @(negedge clk);
`endif
    check(tag, keyout, exp);
  endtask

  logic [127:0] chain_key;
  logic [127:0] rk;
  logic [3:0]   rt;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    build_tables();
    rst_n = 1'b0;
    key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    times = 4'd1;
    #12;
`ifdef AES_KEY_MEMORY_OUTREG_EN
    check("reset_value", keyout, 128'h0);
`else
    check("reset_transparent", keyout, 128'ha0fafe1788542cb123a339392a6c7605);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors; expectations written out as constants.
    apply("kat_t0",  128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
    apply("kat_t1",  128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
    apply("kat_t2",  128'ha0fafe1788542cb123a339392a6c7605, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f);
    apply("kat_t10", 128'hac7766f319fadc2128d12941575c006e, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    apply("zero_t1", 128'h0, 4'd1,  128'h62636363626363636263636362636363);
    apply("zero_t13", 128'h0, 4'd13, 128'h0);
    apply("illegal_t15", 128'h0123456789abcdeffedcba9876543210, 4'd15, 128'h0123456789abcdeffedcba9876543210);

    // Full expansion chain, round 0 through 10; last key is the FIPS-197 round-10 key.
    chain_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    for (int r = 0; r <= 10; r++) begin
      rk = ref_next(chain_key, 4'(r));
      apply($sformatf("chain_r%0d", r), chain_key, 4'(r), rk);
      chain_key = rk;
    end
    check("chain_final", chain_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Mid-stream reset: registered build drops the held key, combinational build ignores it.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
`ifdef AES_KEY_MEMORY_OUTREG_EN
    check("midreset_clear", keyout, 128'h0);
`else
    check("midreset_transparent", keyout, ref_next(key, times));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Random keys over the whole 4-bit round field, legal and illegal.
    for (int i = 0; i < 200; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rt = 4'($urandom_range(0, 15));
      apply($sformatf("rand%0d_t%0d", i, rt), rk, rt, ref_next(rk, rt));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
